// File: rtl/credit_tracker.sv
// credit_tracker: sender-side count of free receiver buffer slots on a credit-based link.
// Latency: a consume or return changes o__credits on the next cycle. o__credits__next shows that value in the current cycle.
// Backpressure: o__credit_avail gates the sender. An over-return or a send without credit latches a sticky error and freezes the tracker until reset.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   i__consume        - sender issues one transfer (uses one credit)
//   i__return         - receiver hands back one credit
//   o__credit_avail   - sender may consume this cycle
//   o__credits        - registered credit count
//   o__credits__next  - combinational next-cycle count
//   o__ready          - tracker is ACTIVE
//   o__underflow_err  - sticky: consume attempted with no credit available
//   o__overflow_err   - sticky: return would exceed MAX_CREDITS
//
// Optional build macro CREDIT_TRACKER_RETURN_BYPASS_EN:
//   - When defined, a credit returned this cycle can be consumed in the same cycle.
//   - This adds a combinational path from i__return to o__credit_avail.

module credit_tracker #(
  parameter int CREDIT_WIDTH = 3,
  parameter int MAX_CREDITS  = 7,
  parameter int INIT_CREDITS = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i__consume,
  input  logic                    i__return,
  output logic                    o__credit_avail,
  output logic [CREDIT_WIDTH-1:0] o__credits,
  output logic [CREDIT_WIDTH-1:0] o__credits__next,
  output logic                    o__ready,
  output logic                    o__underflow_err,
  output logic                    o__overflow_err
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] MAX_C  = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] INIT_C = CREDIT_WIDTH'(INIT_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C  = CREDIT_WIDTH'(1);

  state_t state, state_next;
  logic   underflow_set, overflow_set;
  logic   is_active;

  assign is_active = (state == ST_ACTIVE);
  assign o__ready  = is_active;

`ifdef CREDIT_TRACKER_RETURN_BYPASS_EN
  // A same-cycle return covers a consume at zero credits.
  assign o__credit_avail = is_active && ((o__credits != '0) || i__return);
`else
  assign o__credit_avail = is_active && (o__credits != '0);
`endif

  always_comb begin
    o__credits__next = o__credits;
    state_next       = state;
    underflow_set    = 1'b0;
    overflow_set     = 1'b0;

    case (state)
      ST_INIT: begin
        o__credits__next = INIT_C;
        state_next       = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        underflow_set = i__consume && !o__credit_avail;
        // A consume in the same cycle keeps the count at MAX, so only a lone return overflows.
        overflow_set  = i__return && !i__consume && (o__credits == MAX_C);
        if (underflow_set || overflow_set) begin
          // The offending event and any companion event are dropped. The count freezes.
          state_next = ST_ERROR;
        end else if (i__consume && !i__return) begin
          o__credits__next = o__credits - ONE_C;
        end else if (i__return && !i__consume) begin
          o__credits__next = o__credits + ONE_C;
        end
      end
      default: begin
        // ERROR: frozen until reset; violations are no longer evaluated.
      end
    endcase

    // Reset discards everything that happened in this cycle.
    if (reset) begin
      o__credits__next = o__credits;
      state_next       = ST_INIT;
      underflow_set    = 1'b0;
      overflow_set     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_INIT;
      o__credits       <= '0;
      o__underflow_err <= 1'b0;
      o__overflow_err  <= 1'b0;
    end else begin
      state            <= state_next;
      o__credits       <= o__credits__next;
      o__underflow_err <= o__underflow_err | underflow_set;
      o__overflow_err  <= o__overflow_err | overflow_set;
    end
  end

endmodule

// File: tb/tb_credit_tracker.sv
// Directed testbench for credit_tracker with the default parameters (width 3, max 7, init 7).
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled 1 time unit after the next rising edge.

module tb_credit_tracker;

  logic       clk;
  logic       reset;
  logic       i__consume;
  logic       i__return;
  logic       o__credit_avail;
  logic [2:0] o__credits;
  logic [2:0] o__credits__next;
  logic       o__ready;
  logic       o__underflow_err;
  logic       o__overflow_err;

  int total = 0;
  int bad   = 0;

  credit_tracker #(
    .CREDIT_WIDTH(3),
    .MAX_CREDITS (7),
    .INIT_CREDITS(7)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i__consume      (i__consume),
    .i__return       (i__return),
    .o__credit_avail (o__credit_avail),
    .o__credits      (o__credits),
    .o__credits__next(o__credits__next),
    .o__ready        (o__ready),
    .o__underflow_err(o__underflow_err),
    .o__overflow_err (o__overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, then release and let INIT complete. Expects count 7 and ACTIVE.
  task automatic do_reset();
    reset = 1'b1; i__consume = 1'b0; i__return = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    total++;
    if (o__credits !== 3'd7 || o__ready !== 1'b1) begin
      bad++;
      $display("FAIL reinit: credits=%0d ready=%0b want credits=7 ready=1", o__credits, o__ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i__consume = 1'b0; i__return = 1'b0;
    step(); step();
    total++;
    if (o__credits !== 3'd0 || o__ready !== 1'b0 || o__credit_avail !== 1'b0 ||
        o__underflow_err !== 1'b0 || o__overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: credits=%0d ready=%0b avail=%0b uf=%0b of=%0b want 0 0 0 0 0",
               o__credits, o__ready, o__credit_avail, o__underflow_err, o__overflow_err);
    end
    reset = 1'b0;
    #1;
    total++;
    if (o__credits__next !== 3'd7) begin
      bad++;
      $display("FAIL init_next: credits_next=%0d want 7", o__credits__next);
    end
    step();
    total++;
    if (o__credits !== 3'd7 || o__ready !== 1'b1 || o__credit_avail !== 1'b1) begin
      bad++;
      $display("FAIL init_done: credits=%0d ready=%0b avail=%0b want 7 1 1",
               o__credits, o__ready, o__credit_avail);
    end
  endtask

  task automatic test_consume_drain();
    i__consume = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (o__credits !== 3'(6 - i)) begin
        bad++;
        $display("FAIL drain[%0d]: credits=%0d want %0d", i, o__credits, 6 - i);
      end
    end
    i__consume = 1'b0;
    #1;
    total++;
    if (o__credit_avail !== 1'b0 || o__underflow_err !== 1'b0 || o__overflow_err !== 1'b0 ||
        o__ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_end: avail=%0b uf=%0b of=%0b ready=%0b want 0 0 0 1",
               o__credit_avail, o__underflow_err, o__overflow_err, o__ready);
    end
  endtask

  task automatic test_return_and_both();
    i__return = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (o__credits !== 3'(i + 1)) begin
        bad++;
        $display("FAIL return[%0d]: credits=%0d want %0d", i, o__credits, i + 1);
      end
    end
    i__consume = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (o__credits !== 3'd3 || o__credit_avail !== 1'b1) begin
        bad++;
        $display("FAIL both[%0d]: credits=%0d avail=%0b want 3 1", i, o__credits, o__credit_avail);
      end
    end
    i__consume = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (o__credits !== 3'd7 || o__overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL refill: credits=%0d of=%0b want 7 0", o__credits, o__overflow_err);
    end
    i__return = 1'b0;
  endtask

  task automatic test_overflow();
    // Consume and return together at MAX is legal.
    i__consume = 1'b1; i__return = 1'b1;
    step();
    total++;
    if (o__credits !== 3'd7 || o__overflow_err !== 1'b0 || o__ready !== 1'b1) begin
      bad++;
      $display("FAIL both_at_max: credits=%0d of=%0b ready=%0b want 7 0 1",
               o__credits, o__overflow_err, o__ready);
    end
    i__consume = 1'b0;
    step();
    total++;
    if (o__overflow_err !== 1'b1 || o__credits !== 3'd7 || o__ready !== 1'b0 ||
        o__credit_avail !== 1'b0) begin
      bad++;
      $display("FAIL overflow: of=%0b credits=%0d ready=%0b avail=%0b want 1 7 0 0",
               o__overflow_err, o__credits, o__ready, o__credit_avail);
    end
    i__return = 1'b0; i__consume = 1'b1;
    step(); step();
    i__consume = 1'b0; i__return = 1'b1;
    step();
    total++;
    if (o__credits !== 3'd7 || o__overflow_err !== 1'b1 || o__underflow_err !== 1'b0 ||
        o__ready !== 1'b0 || o__credits__next !== 3'd7) begin
      bad++;
      $display("FAIL error_frozen: credits=%0d next=%0d of=%0b uf=%0b ready=%0b want 7 7 1 0 0",
               o__credits, o__credits__next, o__overflow_err, o__underflow_err, o__ready);
    end
    reset = 1'b1; i__return = 1'b0;
    step();
    total++;
    if (o__overflow_err !== 1'b0 || o__credits !== 3'd0 || o__ready !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: of=%0b credits=%0d ready=%0b want 0 0 0",
               o__overflow_err, o__credits, o__ready);
    end
    do_reset();
  endtask

  task automatic test_consume_return_at_zero();
    i__consume = 1'b1;
    for (int i = 0; i < 7; i++) step();
    i__return = 1'b1;
    #1;
    total++;
`ifdef CREDIT_TRACKER_RETURN_BYPASS_EN
    if (o__credit_avail !== 1'b1) begin
      bad++;
      $display("FAIL bypass_avail: avail=%0b want 1", o__credit_avail);
    end
`else
    if (o__credit_avail !== 1'b0) begin
      bad++;
      $display("FAIL zero_avail: avail=%0b want 0", o__credit_avail);
    end
`endif
    step();
    i__consume = 1'b0; i__return = 1'b0;
    total++;
`ifdef CREDIT_TRACKER_RETURN_BYPASS_EN
    if (o__underflow_err !== 1'b0 || o__credits !== 3'd0 || o__ready !== 1'b1) begin
      bad++;
      $display("FAIL bypass_zero: uf=%0b credits=%0d ready=%0b want 0 0 1",
               o__underflow_err, o__credits, o__ready);
    end
`else
    if (o__underflow_err !== 1'b1 || o__credits !== 3'd0 || o__ready !== 1'b0 ||
        o__overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL underflow: uf=%0b credits=%0d ready=%0b of=%0b want 1 0 0 0",
               o__underflow_err, o__credits, o__ready, o__overflow_err);
    end
`endif
    step();
    total++;
    if (o__credits !== 3'd0) begin
      bad++;
      $display("FAIL zero_hold: credits=%0d want 0", o__credits);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_consume();
    i__consume = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    #1;
    total++;
    if (o__credits !== 3'd4 || o__credits__next !== 3'd4) begin
      bad++;
      $display("FAIL pre_reset: credits=%0d next=%0d want 4 4", o__credits, o__credits__next);
    end
    step();
    total++;
    if (o__credits !== 3'd0 || o__ready !== 1'b0 || o__underflow_err !== 1'b0 ||
        o__overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: credits=%0d ready=%0b uf=%0b of=%0b want 0 0 0 0",
               o__credits, o__ready, o__underflow_err, o__overflow_err);
    end
    reset = 1'b0;
    step();
    i__consume = 1'b0;
    total++;
    if (o__credits !== 3'd7 || o__ready !== 1'b1 || o__underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL init_ignores_consume: credits=%0d ready=%0b uf=%0b want 7 1 0",
               o__credits, o__ready, o__underflow_err);
    end
  endtask

  initial begin
    reset = 1'b1; i__consume = 1'b0; i__return = 1'b0;
    test_reset();
    test_consume_drain();
    test_return_and_both();
    test_overflow();
    test_consume_return_at_zero();
    test_reset_mid_consume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
